// File: rtl/fifo_pkg.sv
// Shared definitions for both clock domains of the asynchronous FIFO.
//   DEF_ADDR_SIZE / DEF_DATA_SIZE : default memory address and word widths.
//   PTR_MAX                       : widest pointer the conversion helpers accept.
//   bin2gray / gray2bin           : pointer code conversions. Callers zero-extend
//                                   into PTR_MAX bits and cast the result back to
//                                   their own pointer width. Leading zeros do not
//                                   change either conversion.
package fifo_pkg;

  localparam int DEF_ADDR_SIZE = 4;
  localparam int DEF_DATA_SIZE = 8;
  localparam int PTR_MAX       = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Binary bit k is the XOR of Gray bits k..MSB.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer for a Gray-coded FIFO pointer crossing into another
// clock domain. The read port and the write-side mirror both use it.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both stages clear to 0
//   d     : pointer from the source domain (unsynchronized)
//   q     : pointer after two destination-clock flops
module sync_w2r #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_rd_port.sv
// Read-domain port of the asynchronous FIFO.
// Brings the write Gray pointer into rclk, owns the read pointer, empty and
// level flags, fetches words from the dual-port memory (registered read, data
// one edge after ren) and presents them as a first-word-fall-through stream
// through a 2-entry output buffer.
//
// Ports:
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   wptr         : write Gray pointer (write domain, unsynchronized)
//   rptr         : registered read Gray pointer, to the write domain
//   raddr, ren   : memory read address (binary) and read enable
//   rdata        : memory data, valid on the rclk edge after ren
//   m_valid, m_ready, m_data : output stream
//   rempty       : no unfetched words in memory
//   raempty      : unfetched words <= AEMPTY_LVL
//   rlevel       : unfetched words in memory, 0..2^ADDR_SIZE
//
// Output handshake: a word transfers on every rclk edge where m_valid and
// m_ready are both high. m_valid never drops without a transfer, and m_data
// holds steady while m_valid is high and m_ready is low.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic [ADDR_SIZE:0]   wptr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic                 ren,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 rempty,
  output logic                 raempty,
  output logic [ADDR_SIZE:0]   rlevel
);

  localparam int PTR_W = ADDR_SIZE + 1;
  localparam logic [ADDR_SIZE:0] AEMPTY_THR = PTR_W'(AEMPTY_LVL);

  logic [ADDR_SIZE:0]   rq2_wptr;
  logic [ADDR_SIZE:0]   rwbin;
  logic [ADDR_SIZE:0]   rbin;
  logic [ADDR_SIZE:0]   rbinnext;
  logic [ADDR_SIZE:0]   rgraynext;
  logic [ADDR_SIZE:0]   rlevel_next;

  logic [DATA_SIZE-1:0] buf_mem [2];
  logic                 buf_head;
  logic                 buf_tail;
  logic [1:0]           buf_cnt;
  logic                 inflight;
  logic                 pop;
  logic [1:0]           occ;
  logic [1:0]           occ_left;

  sync_w2r #(.WIDTH(PTR_W)) u_sync_w2r (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr),
    .q     (rq2_wptr)
  );

  assign rwbin = PTR_W'(gray2bin(PTR_MAX'(rq2_wptr)));

  // Fetch control. Slots are counted as buffered words plus the word coming
  // back from memory this cycle; a fetch is allowed only if, after this
  // cycle's pop, fewer than two slots are claimed. This keeps
  // buf_cnt + inflight <= 2 for any m_ready pattern.
  assign m_valid  = (buf_cnt != 2'd0);
  assign pop      = m_valid & m_ready;
  assign occ      = buf_cnt + {1'b0, inflight};
  assign occ_left = occ - {1'b0, pop};
  assign ren      = ~rempty & (occ_left < 2'd2);

  assign raddr       = rbin[ADDR_SIZE-1:0];
  assign rbinnext    = rbin + {{ADDR_SIZE{1'b0}}, ren};
  assign rgraynext   = PTR_W'(bin2gray(PTR_MAX'(rbinnext)));
  // Modular difference; the extra pointer MSB makes full (2^ADDR_SIZE) distinct from 0.
  assign rlevel_next = rwbin - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin    <= '0;
      rptr    <= '0;
      rempty  <= 1'b1;
      rlevel  <= '0;
      raempty <= 1'b1;
    end else begin
      rbin    <= rbinnext;
      rptr    <= rgraynext;
      // Compared against the next pointer so rempty rises on the same edge
      // that the last word is fetched.
      rempty  <= (rgraynext == rq2_wptr);
      rlevel  <= rlevel_next;
      raempty <= (rlevel_next <= AEMPTY_THR);
    end
  end

  // Output buffer. A fill and a pop on the same edge move head and tail
  // together, leaving buf_cnt unchanged.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      buf_head   <= 1'b0;
      buf_tail   <= 1'b0;
      buf_cnt    <= 2'd0;
      inflight   <= 1'b0;
    end else begin
      inflight <= ren;
      if (inflight) begin
        buf_mem[buf_tail] <= rdata;
        buf_tail          <= ~buf_tail;
      end
      if (pop) begin
        buf_head <= ~buf_head;
      end
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign m_data = buf_mem[buf_head];

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed bench for fifo_rd_port. The bench plays the write side: it loads a
// memory model and moves wptr (Gray) directly. Inputs change and outputs are
// sampled on the falling edge of rclk.
module tb_fifo_rd_port;

  logic       rclk;
  logic       rrst_n;
  logic [4:0] wptr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       ren;
  logic [7:0] rdata;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  logic [3:0] addr_q [$];

  int n_checks = 0;
  int n_errors = 0;

  fifo_rd_port #(.ADDR_SIZE(4), .DATA_SIZE(8), .AEMPTY_LVL(2)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .wptr    (wptr),
    .rptr    (rptr),
    .raddr   (raddr),
    .ren     (ren),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .rempty  (rempty),
    .raempty (raempty),
    .rlevel  (rlevel)
  );

  // clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // memory model: registered read, data on the edge after ren
  always @(posedge rclk) begin
    if (ren) rdata <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one rclk cycle, ending on the falling edge
  task automatic step();
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    wptr    = 5'd0;
    m_ready = 1'b0;
    step();
    step();
    rrst_n = 1'b1;
    step();
  endtask

  initial begin
    rrst_n  = 1'b0;
    wptr    = 5'd0;
    m_ready = 1'b0;
    rdata   = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    @(negedge rclk);
    do_reset();

    // reset state
    chk("rst_rempty",  32'(rempty),  1);
    chk("rst_raempty", 32'(raempty), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_rptr",    32'(rptr),    0);
    chk("rst_rlevel",  32'(rlevel),  0);
    chk("rst_ren",     32'(ren),     0);
    chk("rst_m_data",  32'(m_data),  0);

    // single write: wptr 0 -> Gray 00001, word at address 0
    mem[0] = 8'hA5;
    wptr   = 5'b00001;
    step(); step(); step();   // E1..E3
    chk("one_rempty_fall", 32'(rempty),  0);
    chk("one_ren",         32'(ren),     1);
    chk("one_rlevel",      32'(rlevel),  1);
    chk("one_valid_e3",    32'(m_valid), 0);
    step();                   // E4
    chk("one_valid_e4",    32'(m_valid), 0);
    chk("one_rempty_rise", 32'(rempty),  1);
    chk("one_rptr",        32'(rptr),    5'b00001);
    chk("one_rlevel_0",    32'(rlevel),  0);
    step();                   // E5
    chk("one_valid_e5",    32'(m_valid), 1);
    chk("one_data",        32'(m_data),  8'hA5);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("one_valid_pop",   32'(m_valid), 0);
    chk("one_rempty_end",  32'(rempty),  1);
    chk("one_rptr_end",    32'(rptr),    5'b00001);

    // burst of 16 with m_ready high: one word per cycle, back-to-back
    // pop-and-fill at buf_cnt = 1
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
    m_ready = 1'b1;
    wptr    = 5'b11000;       // Gray of binary 16
    step(); step(); step();   // c = 0 is the falling edge after E3
    for (int c = 0; c < 20; c++) begin
      int exp_lvl;
      exp_lvl = (c < 16) ? 16 - c : 0;
      chk("burst_rlevel",  32'(rlevel),  exp_lvl);
      chk("burst_raempty", 32'(raempty), (exp_lvl <= 2) ? 1 : 0);
      chk("burst_rempty",  32'(rempty),  (c < 16) ? 0 : 1);
      chk("burst_valid",   32'(m_valid), (c >= 2 && c < 18) ? 1 : 0);
      if (c >= 2 && c < 18) chk("burst_data", 32'(m_data), 32'h10 + c - 2);
      step();
    end
    chk("burst_rptr", 32'(rptr), 5'b11000);

    // reset in the middle of a stream: 4 more words, hold them, then reset
    m_ready = 1'b0;
    wptr    = 5'b11110;       // Gray of binary 20
    for (int i = 0; i < 6; i++) step();
    chk("mid_valid_before", 32'(m_valid), 1);
    chk("mid_data_before",  32'(m_data),  8'h10);
    rrst_n = 1'b0;
    wptr   = 5'd0;
    #1;
    chk("mid_rempty",  32'(rempty),  1);
    chk("mid_raempty", 32'(raempty), 1);
    chk("mid_m_valid", 32'(m_valid), 0);
    chk("mid_rptr",    32'(rptr),    0);
    chk("mid_rlevel",  32'(rlevel),  0);
    chk("mid_ren",     32'(ren),     0);
    chk("mid_m_data",  32'(m_data),  0);
    @(negedge rclk);
    do_reset();

    // backpressure: 8 words, consumer stalled, then toggling ready
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'(8'h30 + i);
      exp_q.push_back(8'(8'h30 + i));
    end
    wptr = 5'b01100;          // Gray of binary 8
    for (int i = 0; i < 12; i++) step();
    chk("bp_valid",  32'(m_valid), 1);
    chk("bp_ren",    32'(ren),     0);
    chk("bp_rlevel", 32'(rlevel),  6);
    chk("bp_rptr",   32'(rptr),    5'b00011);
    chk("bp_head",   32'(m_data),  8'h30);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      m_ready = c[0];
      if (m_valid && m_ready) chk("bp_data", 32'(m_data), 32'(exp_q.pop_front()));
      step();
    end
    m_ready = 1'b0;
    chk("bp_drained",    32'(exp_q.size()), 0);
    step();
    chk("bp_valid_end",  32'(m_valid), 0);
    chk("bp_rempty_end", 32'(rempty),  1);
    chk("bp_rlevel_end", 32'(rlevel),  0);

    // wrap: advance both pointers to binary 30, then 4 words across the wrap
    do_reset();
    m_ready = 1'b1;
    wptr    = 5'b10001;       // Gray of binary 30
    for (int i = 0; i < 45; i++) step();
    chk("wrap_pre_rptr",   32'(rptr),    5'b10001);
    chk("wrap_pre_raddr",  32'(raddr),   14);
    chk("wrap_pre_rempty", 32'(rempty),  1);
    chk("wrap_pre_valid",  32'(m_valid), 0);
    mem[14] = 8'hA0; mem[15] = 8'hA1; mem[0] = 8'hA2; mem[1] = 8'hA3;
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    addr_q.push_back(4'd14); addr_q.push_back(4'd15);
    addr_q.push_back(4'd0);  addr_q.push_back(4'd1);
    wptr = 5'b00011;          // Gray of binary 2 (binary 34 mod 32)
    for (int c = 0; c < 20; c++) begin
      if (ren) begin
        if (addr_q.size() > 0) chk("wrap_raddr", 32'(raddr), 32'(addr_q.pop_front()));
        else chk("wrap_extra_ren", 32'(ren), 0);
      end
      if (m_valid) begin
        if (exp_q.size() > 0) chk("wrap_data", 32'(m_data), 32'(exp_q.pop_front()));
        else chk("wrap_extra_word", 32'(m_valid), 0);
      end
      step();
    end
    chk("wrap_addr_done", 32'(addr_q.size()), 0);
    chk("wrap_data_done", 32'(exp_q.size()),  0);
    chk("wrap_rempty",    32'(rempty),        1);
    chk("wrap_rptr",      32'(rptr),          5'b00011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
